sm4_pipe_core: RTL

Parametrised SM4 block-cipher datapath that succeeds the fixed 32-stage encrypt/decrypt pipeline. The number of rounds evaluated per pipeline stage is configurable, trading throughput against area. Each block carries its own encrypt/decrypt mode and a tag, so mixed traffic can be interleaved. The block has a valid/ready handshake on both sides with full backpressure. It sits between the key-expansion unit, which supplies 32 round keys, and the mode/stream wrapper.

---
 rtl/sm4_pkg.sv | 69 ++++++
 rtl/sm4_round.sv | 19 +
 rtl/sm4_pipe_core.sv | 115 +++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// SM4 primitives and the payload type carried by each stage.
// Shared by the pipelined core and its round slice.
package sm4_pkg;

  localparam int TAG_MAX_W = 16;

  localparam logic [0:255][7:0] SBOX = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
    8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
    8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
    8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
    8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
    8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
    8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
    8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
    8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
    8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
    8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
    8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
    8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
    8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
    8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
    8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
    8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef struct packed {
    logic                 dec;
    logic [TAG_MAX_W-1:0] tag;
    logic [127:0]         x;
  } sm4_pay_t;

  function automatic bit rps_legal(input int rps);
    return rps inside {1, 2, 4, 8, 16, 32};
  endfunction

  function automatic logic [31:0] rotl(
    input logic [31:0] v,
    input int          n
  );
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] sbox_tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]],
            SBOX[a[15:8]],  SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] l_transform(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10)
             ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

endpackage

// File: rtl/sm4_round.sv
// One SM4 round: shifts the word window and appends
// X[i+4] = X[i] ^ T(X[i+1]^X[i+2]^X[i+3]^rk).
module sm4_round
  import sm4_pkg::*;
(
  input  logic [127:0] x_in,
  input  logic [31:0]  rk,
  output logic [127:0] x_out
);

  logic [31:0] mix;

  always_comb begin
    mix   = x_in[95:64] ^ x_in[63:32] ^ x_in[31:0] ^ rk;
    x_out = {x_in[95:0],
             x_in[127:96] ^ l_transform(sbox_tau(mix))};
  end

endmodule

// File: rtl/sm4_pipe_core.sv
// SM4 encrypt/decrypt pipeline, RPS rounds per stage,
// per-block mode and tag, global stall on output backpressure.
module sm4_pipe_core
  import sm4_pkg::*;
#(
  parameter int RPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1023:0]    rk_in,
  input  logic             key_valid_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_dec,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy_out
);

  localparam int STAGES = 32 / RPS;
  localparam int LAST   = STAGES - 1;

  if (!rps_legal(RPS)) begin : g_bad_rps
    $error("sm4_pipe_core: RPS must be 1, 2, 4, 8, 16 or 32");
  end
  if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
    $error("sm4_pipe_core: TAG_W out of range");
  end

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  sm4_pay_t          pay_q [STAGES];
  sm4_pay_t          pay_d [STAGES];
  sm4_pay_t          src   [STAGES];
  logic [127:0]      res   [STAGES];
  logic              stall;
  logic              accept;

  always_comb begin
    stall     = vld_q[LAST] & ~out_ready;
    in_ready  = key_valid_in & ~stall;
    accept    = in_valid & in_ready;
    out_valid = vld_q[LAST];
    out_data  = pay_q[LAST].x;
    out_tag   = pay_q[LAST].tag[TAG_W-1:0];
    busy_out  = |vld_q;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign src[s] = '{dec: in_dec,
                        tag: TAG_MAX_W'(in_tag),
                        x:   in_data};
    end else begin : g_body
      assign src[s] = pay_q[s-1];
    end

    for (genvar r = 0; r < RPS; r++) begin : g_rnd
      localparam int RI = s * RPS + r;
      logic [127:0] x_i;
      logic [127:0] x_o;
      logic [31:0]  rk;
      if (r == 0) begin : g_first
        assign x_i = src[s].x;
      end else begin : g_next
        assign x_i = g_rnd[r-1].x_o;
      end
      // decrypt walks the same schedule backwards
      assign rk = src[s].dec ? rk_in[32*(31-RI) +: 32]
                             : rk_in[32*RI +: 32];
      sm4_round u_round (
        .x_in  (x_i),
        .rk    (rk),
        .x_out (x_o)
      );
    end

    if (s == LAST) begin : g_rev
      assign res[s] = {g_rnd[RPS-1].x_o[31:0],
                       g_rnd[RPS-1].x_o[63:32],
                       g_rnd[RPS-1].x_o[95:64],
                       g_rnd[RPS-1].x_o[127:96]};
    end else begin : g_fwd
      assign res[s] = g_rnd[RPS-1].x_o;
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < STAGES; s++) begin
      pay_d[s] = pay_q[s];
      if (!stall) begin
        pay_d[s]   = src[s];
        pay_d[s].x = res[s];
      end
    end
    if (!stall) vld_d = STAGES'({vld_q, accept});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) pay_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < STAGES; s++) pay_q[s] <= pay_d[s];
    end
  end

endmodule
